// File: rtl/aoc_grid_solver.sv
// aoc_grid_solver: GRID_W x GRID_H occupancy grid solver on a 4-bit register bus.
// Streams raster passes through a 3x3 window and counts occupied cells with fewer
// than THRESH occupied neighbours; mode 1 removes them and repeats until stable.
// Optional feature macro: AOC_SOLVER_IRQ_EN adds the irq output and STATUS bit2.
module aoc_grid_solver #(
   parameter int unsigned GRID_W = 10,
   parameter int unsigned GRID_H = 10,
   parameter int unsigned THRESH = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [3:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   input  logic        reg_write_strobe,
   output logic [31:0] reg_rdata
`ifdef AOC_SOLVER_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int unsigned N         = GRID_W * GRID_H;
   localparam int unsigned ADDR_W    = $clog2(N);
   localparam int unsigned PW        = $clog2(N + 1);
   localparam int unsigned KW        = $clog2(N + GRID_W + 1);
   localparam int unsigned CW        = $clog2(GRID_W);
   localparam int unsigned RW        = $clog2(GRID_H);
   localparam int unsigned SRW       = 2 * GRID_W + 2;
   localparam int unsigned LAST_FEED = N + GRID_W;

   typedef enum logic [2:0] {StIdle, StPass, StDrain, StCheck, StDone} state_e;

   state_e           state_q;
   logic             mode_q, done_q, removed_q;
   logic [CNT_W-1:0] count_q, passes_q;
   logic [PW-1:0]    ptr_q;
   logic [KW-1:0]    feed_q;
   logic [CW-1:0]    col_q;
   logic [RW-1:0]    row_q;
   logic [SRW-1:0]   sr_q;
   logic             grid_mem [N];

   logic             wr_ctrl, wr_addr, wr_data, start, ptr_ok, busy, idle_like;
   logic             in_bit, centre_vld, accessible, remove, done_rise, irq_bit;
   logic             has_l, has_r, has_u, has_d;
   logic [SRW:0]     win;
   logic [KW-1:0]    centre_idx;
   logic [3:0]       nsum;
   logic [31:0]      count_ext, passes_ext;
   logic             data_bit;
   logic             unused_wdata;

   assign unused_wdata = ^reg_wdata;

   // Bus decode and window taps; win[j] holds cell (feed - j), centre sits at j = GRID_W+1
   always_comb begin
      wr_ctrl    = reg_write_strobe && (reg_addr == 4'd0);
      wr_addr    = reg_write_strobe && (reg_addr == 4'd2);
      wr_data    = reg_write_strobe && (reg_addr == 4'd3);
      start      = wr_ctrl && reg_wdata[0];
      ptr_ok     = ptr_q < PW'(N);
      busy       = (state_q == StPass) || (state_q == StDrain) || (state_q == StCheck);
      idle_like  = (state_q == StIdle) || (state_q == StDone);
      in_bit     = (state_q == StPass) ? grid_mem[feed_q[ADDR_W-1:0]] : 1'b0;
      win        = {sr_q, in_bit};
      centre_vld = ((state_q == StPass) || (state_q == StDrain)) &&
                   (feed_q >= KW'(GRID_W + 1));
      centre_idx = feed_q - KW'(GRID_W + 1);
      has_l      = col_q != '0;
      has_r      = col_q != CW'(GRID_W - 1);
      has_u      = row_q != '0;
      has_d      = row_q != RW'(GRID_H - 1);
      nsum       = 4'(win[0] & has_d & has_r) +
                   4'(win[1] & has_d) +
                   4'(win[2] & has_d & has_l) +
                   4'(win[GRID_W] & has_r) +
                   4'(win[GRID_W + 2] & has_l) +
                   4'(win[2 * GRID_W] & has_u & has_r) +
                   4'(win[2 * GRID_W + 1] & has_u) +
                   4'(win[2 * GRID_W + 2] & has_u & has_l);
      accessible = centre_vld && win[GRID_W + 1] && (nsum < 4'(THRESH));
      remove     = accessible && mode_q;
      done_rise  = (state_q == StCheck) && !(mode_q && removed_q);
   end

   // Control FSM, counters, load pointer and the sliding window
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q   <= StIdle;
         mode_q    <= 1'b0;
         done_q    <= 1'b0;
         removed_q <= 1'b0;
         count_q   <= '0;
         passes_q  <= '0;
         ptr_q     <= '0;
         feed_q    <= '0;
         col_q     <= '0;
         row_q     <= '0;
         sr_q      <= '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  mode_q    <= reg_wdata[1];
                  count_q   <= '0;
                  passes_q  <= '0;
                  done_q    <= 1'b0;
                  removed_q <= 1'b0;
                  feed_q    <= '0;
                  col_q     <= '0;
                  row_q     <= '0;
                  sr_q      <= '0;
                  state_q   <= StPass;
               end else if (wr_addr) begin
                  ptr_q <= PW'(reg_wdata[ADDR_W-1:0]);
               end else if (wr_data && ptr_ok) begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            StPass, StDrain: begin
               sr_q   <= win[SRW-1:0];
               feed_q <= feed_q + 1'b1;
               if (centre_vld) begin
                  if (col_q == CW'(GRID_W - 1)) begin
                     col_q <= '0;
                     row_q <= row_q + 1'b1;
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
               if (accessible) begin
                  if (count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
                  if (mode_q) removed_q <= 1'b1;
               end
               if ((state_q == StPass) && (feed_q == KW'(N - 1))) state_q <= StDrain;
               if ((state_q == StDrain) && (feed_q == KW'(LAST_FEED))) state_q <= StCheck;
            end
            StCheck: begin
               if (passes_q != {CNT_W{1'b1}}) passes_q <= passes_q + 1'b1;
               if (mode_q && removed_q) begin
                  removed_q <= 1'b0;
                  feed_q    <= '0;
                  col_q     <= '0;
                  row_q     <= '0;
                  sr_q      <= '0;
                  state_q   <= StPass;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Grid RAM: host loads while idle, removals write back behind the read front
   always_ff @(posedge clock) begin
      if (wr_data && idle_like && ptr_ok) begin
         grid_mem[ptr_q[ADDR_W-1:0]] <= reg_wdata[0];
      end else if (remove) begin
         grid_mem[centre_idx[ADDR_W-1:0]] <= 1'b0;
      end
   end

`ifdef AOC_SOLVER_IRQ_EN
   logic irq_q;

   // Sticky interrupt; a coincident ack loses to the done rise
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         irq_q <= 1'b0;
      end else if (done_rise) begin
         irq_q <= 1'b1;
      end else if (wr_ctrl && reg_wdata[2]) begin
         irq_q <= 1'b0;
      end
   end

   assign irq     = irq_q;
   assign irq_bit = irq_q;
`else
   logic unused_done_rise;
   assign unused_done_rise = done_rise;
   assign irq_bit          = 1'b0;
`endif

   // Combinational register read mux
   always_comb begin
      count_ext  = 32'(count_q);
      passes_ext = 32'(passes_q);
      data_bit   = ptr_ok ? grid_mem[ptr_q[ADDR_W-1:0]] : 1'b0;
      case (reg_addr)
         4'd1:    reg_rdata = {count_ext[15:0], 13'b0, irq_bit, busy, done_q};
         4'd3:    reg_rdata = {31'b0, data_bit};
         4'd4:    reg_rdata = count_ext;
         4'd5:    reg_rdata = passes_ext;
         default: reg_rdata = 32'b0;
      endcase
   end

endmodule

// File: tb/tb_aoc_grid_solver.sv
// Randomized self-checking bench for aoc_grid_solver (10x10 default build),
// compared against a behavioural whole-grid model.
module tb_aoc_grid_solver;

   localparam int W = 10;
   localparam int H = 10;
   localparam int N = W * H;
   localparam int T = 4;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  reg_addr = 4'd0;
   logic [31:0] reg_wdata = 32'd0;
   logic        reg_write_strobe = 1'b0;
   logic [31:0] reg_rdata;
`ifdef AOC_SOLVER_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   aoc_grid_solver dut (
      .clock            (clock),
      .clear            (clear),
      .reg_addr         (reg_addr),
      .reg_wdata        (reg_wdata),
      .reg_write_strobe (reg_write_strobe),
      .reg_rdata        (reg_rdata)
`ifdef AOC_SOLVER_IRQ_EN
      ,
      .irq              (irq)
`endif
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clock);
      reg_addr         = a;
      reg_wdata        = d;
      reg_write_strobe = 1'b1;
      @(negedge clock);
      reg_write_strobe = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clock);
      reg_addr = a;
      #1 d = reg_rdata;
   endtask

   task automatic load_grid(input logic [N-1:0] g);
      bus_write(4'd2, 32'd0);
      for (int i = 0; i < N; i++) bus_write(4'd3, {31'b0, g[i]});
   endtask

   task automatic read_grid(output logic [N-1:0] g);
      logic [31:0] d;
      for (int i = 0; i < N; i++) begin
         bus_write(4'd2, 32'(i));
         bus_read(4'd3, d);
         g[i] = d[0];
      end
   endtask

   // Polls STATUS.done; cyc counts clock edges since the start edge
   task automatic wait_done(output int cyc);
      cyc      = 1;
      reg_addr = 4'd1;
      #1;
      while (!reg_rdata[0] && cyc < 20000) begin
         @(negedge clock);
         #1 cyc++;
      end
      if (!reg_rdata[0]) check_eq("done_timeout", 128'd0, 128'd1);
   endtask

   task automatic run_solver(input logic mode, output int cyc);
      bus_write(4'd0, {30'b0, mode, 1'b1});
      wait_done(cyc);
   endtask

   // Whole-grid reference: Jacobi passes over a snapshot with bounds-checked neighbours
   function automatic void model(input logic [N-1:0] gi, input logic mode,
                                 output int cnt, output int np, output logic [N-1:0] go);
      logic [N-1:0] g;
      logic [N-1:0] rm;
      int nb;
      g   = gi;
      cnt = 0;
      np  = 0;
      do begin
         rm = '0;
         for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
               if (g[r * W + c]) begin
                  nb = 0;
                  for (int dr = -1; dr <= 1; dr++) begin
                     for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H &&
                            c + dc >= 0 && c + dc < W) begin
                           nb += int'(g[(r + dr) * W + c + dc]);
                        end
                     end
                  end
                  if (nb < T) rm[r * W + c] = 1'b1;
               end
            end
         end
         np++;
         cnt += $countones(rm);
         if (mode) g = g & ~rm;
      end while (mode && rm != '0);
      go = g;
   endfunction

   task automatic run_and_check(input string tag, input logic [N-1:0] g, input logic mode);
      int cyc, ecnt, enp;
      logic [N-1:0] eg, rg;
      logic [31:0] d;
      model(g, mode, ecnt, enp, eg);
      load_grid(g);
      run_solver(mode, cyc);
      bus_read(4'd4, d);
      check_eq({tag, "_count"}, d, ecnt);
      bus_read(4'd5, d);
      check_eq({tag, "_passes"}, d, enp);
      read_grid(rg);
      check_eq({tag, "_grid"}, rg, eg);
   endtask

   initial begin
      string aoc [10];
      logic [N-1:0] g, rg, eg;
      logic [31:0] d;
      int cyc, ecnt, enp, dens;

      aoc[0] = "..@@.@@@@.";
      aoc[1] = "@@@.@.@.@@";
      aoc[2] = "@@@@@.@.@@";
      aoc[3] = "@.@@@@..@.";
      aoc[4] = "@@.@@@@.@@";
      aoc[5] = ".@@@@@@@.@";
      aoc[6] = ".@.@.@.@@@";
      aoc[7] = "@.@@@.@@@@";
      aoc[8] = ".@@@@@@@@.";
      aoc[9] = "@.@.@@@.@.";

      // Reset state
      repeat (3) @(negedge clock);
      reg_addr = 4'd1;
      #1 check_eq("rst_status_in_reset", reg_rdata, 32'd0);
      clear = 1'b1;
      bus_read(4'd1, d);
      check_eq("rst_status", d, 32'd0);
      bus_read(4'd4, d);
      check_eq("rst_count", d, 32'd0);
      bus_read(4'd5, d);
      check_eq("rst_passes", d, 32'd0);
      bus_read(4'd7, d);
      check_eq("rst_unmapped", d, 32'd0);

      // AoC example grid, mode 0 then mode 1
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) g[r * W + c] = (aoc[r][c] == "@");
      load_grid(g);
      run_solver(1'b0, cyc);
      bus_read(4'd1, d);
      check_eq("aoc0_status", d, {16'd13, 13'b0, 1'b0 /*irq slot checked below*/, 1'b0, 1'b1}
               | {29'b0, d[2], 2'b0});
      bus_read(4'd4, d);
      check_eq("aoc0_count", d, 32'd13);
      bus_read(4'd5, d);
      check_eq("aoc0_passes", d, 32'd1);
      read_grid(rg);
      check_eq("aoc0_grid", rg, g);

      model(g, 1'b1, ecnt, enp, eg);
      check_eq("aoc1_model_count", 128'(ecnt), 128'd43);
      load_grid(g);
      run_solver(1'b1, cyc);
      bus_read(4'd4, d);
      check_eq("aoc1_count", d, 32'd43);
      bus_read(4'd5, d);
      check_eq("aoc1_passes", d, 32'd10);
      read_grid(rg);
      check_eq("aoc1_grid", rg, eg);

      // All-empty, mode 1: single pass within the latency bound
      g = '0;
      load_grid(g);
      run_solver(1'b1, cyc);
      bus_read(4'd4, d);
      check_eq("empty_count", d, 32'd0);
      bus_read(4'd5, d);
      check_eq("empty_passes", d, 32'd1);
      check_eq("empty_latency_ok", 128'(cyc <= N + W + 4), 128'd1);

      // All-full grid, both modes
      run_and_check("full_m0", '1, 1'b0);
      run_and_check("full_m1", '1, 1'b1);

      // Random grids and modes
      for (int it = 0; it < 6; it++) begin
         dens = $urandom_range(20, 90);
         for (int i = 0; i < N; i++) g[i] = ($urandom_range(0, 99) < dens);
         run_and_check($sformatf("rand%0d", it), g, 1'(it & 1));
      end

      // Start and DATA writes while busy are ignored
      for (int i = 0; i < N; i++) g[i] = ($urandom_range(0, 99) < 60);
      model(g, 1'b1, ecnt, enp, eg);
      load_grid(g);
      bus_write(4'd2, 32'd5);
      bus_write(4'd0, 32'h3);
      repeat (20) @(negedge clock);
      bus_write(4'd0, 32'h1);
      bus_write(4'd3, {31'b0, ~eg[5]});
      bus_write(4'd2, 32'd40);
      wait_done(cyc);
      bus_read(4'd4, d);
      check_eq("busy_count", d, ecnt);
      bus_read(4'd5, d);
      check_eq("busy_passes", d, enp);
      bus_read(4'd3, d);
      check_eq("busy_ptr_data", d, {31'b0, eg[5]});
      read_grid(rg);
      check_eq("busy_grid", rg, eg);

      // Asynchronous clear mid-pass, then a fresh run
      load_grid('1);
      bus_write(4'd0, 32'h3);
      repeat (30) @(negedge clock);
      #2 clear = 1'b0;
      reg_addr = 4'd1;
      #1 check_eq("clr_status", reg_rdata, 32'd0);
      reg_addr = 4'd4;
      #1 check_eq("clr_count", reg_rdata, 32'd0);
      reg_addr = 4'd5;
      #1 check_eq("clr_passes", reg_rdata, 32'd0);
      @(negedge clock);
      clear = 1'b1;
      for (int i = 0; i < N; i++) g[i] = ($urandom_range(0, 99) < 50);
      run_and_check("post_clr", g, 1'b0);

      // Interrupt behaviour
`ifdef AOC_SOLVER_IRQ_EN
      #1 check_eq("irq_set", irq, 1'b1);
      bus_read(4'd1, d);
      check_eq("irq_status_bit", d[2], 1'b1);
      bus_read(4'd4, d);
      bus_read(4'd5, d);
      #1 check_eq("irq_hold", irq, 1'b1);
      bus_write(4'd0, 32'h0);
      #1 check_eq("irq_no_ack", irq, 1'b1);
      bus_write(4'd0, 32'h4);
      #1 check_eq("irq_ack", irq, 1'b0);
      bus_read(4'd1, d);
      check_eq("irq_status_clr", d[2], 1'b0);
`else
      bus_read(4'd1, d);
      check_eq("status_bit2_zero", d[2], 1'b0);
      bus_write(4'd0, 32'h4);
      bus_read(4'd1, d);
      check_eq("status_after_ack", d[1:0], 2'b01);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
